// File: rtl/pc_sequencer_if.sv
// Bus between the control unit and the program-counter sequencer.
// The master drives the update request. The slave (the sequencer) returns
// the fetch address and the return-address-stack status.
interface pc_sequencer_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             we;
  logic [2:0]       mode;
  logic [WIDTH-1:0] data;
  logic [15:0]      imm;
  logic             clrFault;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] rasCount;
  logic             rasEmpty;
  logic             rasFull;
  logic             fault;

  modport master (
    output we, mode, data, imm, clrFault,
    input  dout, rasCount, rasEmpty, rasFull, fault
  );

  modport slave (
    input  we, mode, data, imm, clrFault,
    output dout, rasCount, rasEmpty, rasFull, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack.
// The next PC is selected from: sequential, relative branch, absolute jump,
// call, or return. Every computed target is word aligned.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input logic             i_clk,
  input logic             i_reset_n,
  pc_sequencer_if.slave   bus
);
  localparam int               PTR_W      = $clog2(RAS_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

  typedef enum logic [2:0] {
    MODE_SEQ    = 3'b000,
    MODE_BRANCH = 3'b001,
    MODE_JUMP   = 3'b010,
    MODE_CALL   = 3'b011,
    MODE_RET    = 3'b100
  } mode_t;

  logic [WIDTH-1:0] r_pc;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_fault;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];

  mode_t            w_mode;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_immExt;
  logic [WIDTH-1:0] w_offset;
  logic [WIDTH-1:0] w_branch;
  logic [WIDTH-1:0] w_pcNext;
  logic [PTR_W-1:0] w_ptrNext;
  logic [CNT_W-1:0] w_countNext;
  logic             w_faultSet;
  logic             w_faultNext;
  logic             w_push;

  assign w_mode   = mode_t'(bus.mode);
  assign w_seq    = r_pc + INC_W;
  assign w_immExt = WIDTH'($signed(bus.imm));
  assign w_offset = w_immExt << 2;
  assign w_branch = w_seq + w_offset;

  // Next-PC selection and stack bookkeeping; a stall holds everything.
  always_comb begin
    w_pcNext    = r_pc;
    w_ptrNext   = r_ptr;
    w_countNext = r_count;
    w_faultSet  = 1'b0;
    w_push      = 1'b0;
    if (bus.we) begin
      case (w_mode)
        MODE_SEQ:    w_pcNext = w_seq & ALIGN_MASK;
        MODE_BRANCH: w_pcNext = w_branch & ALIGN_MASK;
        MODE_JUMP:   w_pcNext = bus.data & ALIGN_MASK;
        MODE_CALL: begin
          w_push    = 1'b1;
          w_pcNext  = bus.data & ALIGN_MASK;
          w_ptrNext = r_ptr + 1'b1;
          if (r_count != CNT_MAX) begin
            w_countNext = r_count + 1'b1;
          end
        end
        MODE_RET: begin
          if (r_count != '0) begin
            w_pcNext    = r_ras[r_ptr] & ALIGN_MASK;
            w_ptrNext   = r_ptr - 1'b1;
            w_countNext = r_count - 1'b1;
          end else begin
            w_pcNext   = w_seq & ALIGN_MASK;
            w_faultSet = 1'b1;
          end
        end
        default: w_faultSet = 1'b1;
      endcase
    end
    if (w_faultSet) begin
      w_faultNext = 1'b1;
    end else if (bus.clrFault) begin
      w_faultNext = 1'b0;
    end else begin
      w_faultNext = r_fault;
    end
  end

  // PC, stack pointer, entry count and sticky fault register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc    <= RESET_VECTOR;
      r_ptr   <= '0;
      r_count <= '0;
      r_fault <= 1'b0;
    end else begin
      r_pc    <= w_pcNext;
      r_ptr   <= w_ptrNext;
      r_count <= w_countNext;
      r_fault <= w_faultNext;
    end
  end

  // Stack storage; a push into a full stack overwrites the oldest entry.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_ras[w_ptrNext] <= w_seq & ALIGN_MASK;
    end
  end

  assign bus.dout     = r_pc;
  assign bus.rasCount = r_count;
  assign bus.rasEmpty = (r_count == '0);
  assign bus.rasFull  = (r_count == CNT_MAX);
  assign bus.fault    = r_fault;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a reference model and a scoreboard.
module tb_pc_sequencer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    int          count;
    logic        fault;
  } exp_t;

  logic clk;
  logic resetN;
  int   checkCount;
  int   passCount;
  exp_t sbQueue[$];

  logic [31:0] mPc;
  logic [31:0] mStack[$];
  logic        mFault;

  pc_sequencer_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();

  pc_sequencer #(
    .WIDTH(WIDTH), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_reset_n(resetN),
    .bus(bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mPc = 32'h0;
    mStack.delete();
    mFault = 1'b0;
  endtask

  // Reference model of one clock edge, evaluated from the pre-edge state.
  task automatic modelStep(input logic we, input logic [2:0] mode,
                           input logic [31:0] data, input logic [15:0] imm,
                           input logic clr);
    logic [31:0] seq;
    logic [31:0] off;
    logic        setF;
    seq  = mPc + 32'd4;
    off  = {{16{imm[15]}}, imm} << 2;
    setF = 1'b0;
    if (we) begin
      case (mode)
        3'd0: mPc = seq & ~32'd3;
        3'd1: mPc = (seq + off) & ~32'd3;
        3'd2: mPc = data & ~32'd3;
        3'd3: begin
          mStack.push_back(seq);
          if (mStack.size() > DEPTH) void'(mStack.pop_front());
          mPc = data & ~32'd3;
        end
        3'd4: begin
          if (mStack.size() > 0) mPc = mStack.pop_back() & ~32'd3;
          else begin
            mPc  = seq & ~32'd3;
            setF = 1'b1;
          end
        end
        default: setF = 1'b1;
      endcase
    end
    if (setF) mFault = 1'b1;
    else if (clr) mFault = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkCount++;
      $error("[TB] FAIL scoreboard: observed=empty expected=entry");
      return;
    end
    e = sbQueue.pop_front();
    checkValue({e.tag, " dout"}, bus.dout, e.pc);
    checkValue({e.tag, " count"}, 32'(bus.rasCount), 32'(e.count));
    checkValue({e.tag, " empty"}, 32'(bus.rasEmpty), 32'(e.count == 0));
    checkValue({e.tag, " full"}, 32'(bus.rasFull), 32'(e.count == DEPTH));
    checkValue({e.tag, " fault"}, 32'(bus.fault), 32'(e.fault));
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] mode,
                               input logic [31:0] data, input logic [15:0] imm,
                               input logic clr);
    exp_t e;
    bus.we       = we;
    bus.mode     = mode;
    bus.data     = data;
    bus.imm      = imm;
    bus.clrFault = clr;
    modelStep(we, mode, data, imm, clr);
    e.tag   = tag;
    e.pc    = mPc;
    e.count = mStack.size();
    e.fault = mFault;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Directed sequence following the block's test plan.
  initial begin
    checkCount = 0;
    passCount  = 0;
    resetN       = 1'b0;
    bus.we       = 1'b0;
    bus.mode     = 3'd0;
    bus.data     = '0;
    bus.imm      = '0;
    bus.clrFault = 1'b0;
    modelReset();

    #2;
    checkValue("reset dout", bus.dout, 32'h0);
    checkValue("reset count", 32'(bus.rasCount), 32'd0);
    checkValue("reset fault", 32'(bus.fault), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetN = 1'b1;

    applyStimulus("seq1", 1, 3'd0, 0, 0, 0);
    applyStimulus("seq2", 1, 3'd0, 0, 0, 0);
    applyStimulus("seq3", 1, 3'd0, 0, 0, 0);
    checkValue("seq3 plan", bus.dout, 32'd12);

    applyStimulus("jmp100", 1, 3'd2, 32'h100, 0, 0);
    applyStimulus("brneg", 1, 3'd1, 0, 16'hFFFE, 0);
    checkValue("brneg plan", bus.dout, 32'hFC);
    applyStimulus("jmp100b", 1, 3'd2, 32'h100, 0, 0);
    applyStimulus("brpos", 1, 3'd1, 0, 16'h0003, 0);
    checkValue("brpos plan", bus.dout, 32'h110);
    applyStimulus("stall1", 0, 3'd6, 32'h5555, 16'h7, 0);
    applyStimulus("stall2", 0, 3'd3, 32'h7777, 16'h1, 0);
    checkValue("stall plan", bus.dout, 32'h110);

    applyStimulus("jmp20", 1, 3'd2, 32'h20, 0, 0);
    applyStimulus("call400", 1, 3'd3, 32'h400, 0, 0);
    applyStimulus("seq404", 1, 3'd0, 0, 0, 0);
    applyStimulus("ret24", 1, 3'd4, 0, 0, 0);
    checkValue("ret24 plan", bus.dout, 32'h24);

    applyStimulus("jmp0", 1, 3'd2, 32'h0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus($sformatf("ncall%0d", i), 1, 3'd3, 32'(i * 4), 0, 0);
    end
    checkValue("overflow full", 32'(bus.rasFull), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus($sformatf("nret%0d", i), 1, 3'd4, 0, 0, 0);
    end
    checkValue("nret4 plan", bus.dout, 32'h08);
    applyStimulus("retEmpty", 1, 3'd4, 0, 0, 0);
    checkValue("retEmpty plan", bus.dout, 32'h0C);

    applyStimulus("clr1", 0, 3'd0, 0, 0, 1);
    applyStimulus("rsvd110", 1, 3'd6, 32'h999, 0, 0);
    applyStimulus("rsvd111", 1, 3'd7, 0, 0, 0);
    applyStimulus("clr2", 0, 3'd0, 0, 0, 1);
    applyStimulus("clrVsRet", 1, 3'd4, 0, 0, 1);
    applyStimulus("clrWithSeq", 1, 3'd0, 0, 0, 1);
    applyStimulus("rsvd101", 1, 3'd5, 0, 0, 0);

    applyStimulus("call200", 1, 3'd3, 32'h200, 0, 0);
    applyStimulus("call300", 1, 3'd3, 32'h300, 0, 0);
    #2;
    resetN = 1'b0;
    #1;
    modelReset();
    checkValue("async dout", bus.dout, 32'h0);
    checkValue("async count", 32'(bus.rasCount), 32'd0);
    checkValue("async empty", 32'(bus.rasEmpty), 32'd1);
    checkValue("async fault", 32'(bus.fault), 32'd0);
    #1;
    resetN = 1'b1;
    applyStimulus("retAfterRst", 1, 3'd4, 0, 0, 0);
    checkValue("retAfterRst plan", 32'(bus.fault), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit; successor to the single-register PC.
- Holds the current PC and computes the next PC from a mode select: sequential, relative branch, absolute jump, call, or return.
- Contains an internal return-address stack (RAS) for call/return.
- Sits between control unit and instruction memory; Dout drives the instruction-fetch address.

Parameters:
- WIDTH, 32, PC/data width in bits (>=8).
- RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits).
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries (power of two, >=2).

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- WE  input  1  PC update enable; 0 = stall (PC and RAS hold).
- Mode  input  3  next-PC select (encoding under Behaviour).
- Data  input  WIDTH  absolute target for jump/call.
- Imm  input  16  signed word offset for branch.
- clr_fault  input  1  synchronous clear of the fault flag.
- Dout  output  WIDTH  current PC.
- ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  output  1  ras_count == 0.
- ras_full  output  1  ras_count == RAS_DEPTH.
- fault  output  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - Dout = RESET_VECTOR; ras_count = 0; RAS pointer = 0; fault = 0.
  - RAS contents don't-care.
  - Deassertion takes effect at the next CLK edge.
- Latency: Mode, Data and Imm sampled at a rising edge with WE=1; the new Dout is visible after that edge (1 cycle).
- All arithmetic is modulo 2^WIDTH; no overflow detection. The low 2 bits of every computed target are forced to 0.
- Let seq = Dout + INC.
- Mode encoding (applies only when WE=1):
  - 000 SEQ: Dout <= seq.
  - 001 BRANCH: Dout <= seq + (sign_extend(Imm) << 2).
  - 010 JUMP: Dout <= Data.
  - 011 CALL: push seq onto RAS; Dout <= Data.
  - 100 RET, RAS non-empty: pop; Dout <= popped value.
  - 100 RET, RAS empty: Dout <= seq; fault <= 1; ras_count stays 0.
  - 101-111 reserved: Dout holds; fault <= 1.
- RAS is a circular buffer with top-of-stack pointer.
  - Push: pointer increments, value written at the new top; ras_count saturates at RAS_DEPTH.
  - Push when full: the oldest entry is overwritten (wrap-around); ras_full stays 1; fault is not set.
  - Pop: pointer decrements mod RAS_DEPTH; ras_count decrements.
- WE=0: no state changes except fault clearing; Mode is ignored, and reserved modes do not set fault.
- fault:
  - Set as listed above; cleared by clr_fault=1 at a rising edge.
  - clr_fault has no effect if a set condition occurs in the same cycle (set wins).
- Simultaneous events: asynchronous reset overrides all. WE and clr_fault are independent.
- Reset mid-sequence (e.g. during a call chain): RAS is emptied immediately and Dout returns to RESET_VECTOR.

Test Plan:
- Reset/SEQ: reset=0, RESET_VECTOR=0 -> Dout=0 with no clock edge; release, 3 cycles WE=1 Mode=000 -> Dout 4, 8, 12.
- Branch and stall:
  - Dout=0x100, Mode=001, Imm=0xFFFE -> Dout=0x100+4-8=0xFC.
  - Imm=3 -> 0x110.
  - WE=0 for 2 cycles -> Dout holds 0x110.
- Call/return: Dout=0x20, CALL Data=0x400 -> Dout=0x400, ras_count=1; SEQ; RET -> Dout=0x24, ras_empty=1, fault=0.
- RAS overflow (RAS_DEPTH=4): 5 nested CALLs pushing 0x04, 0x08, 0x0C, 0x10, 0x14 -> ras_full=1, count=4; 4 RETs return 0x14, 0x10, 0x0C, 0x08; a 5th RET -> Dout=seq, fault=1.
- Fault control: Mode=110 with WE=1 -> Dout holds, fault=1; clr_fault=1 alone -> fault=0; clr_fault=1 together with RET on empty RAS -> fault stays 1.
- Async reset mid-operation: after 2 CALLs, pull reset low between edges -> Dout=RESET_VECTOR, ras_count=0, fault=0 immediately; first RET after release -> fault=1.
